// File: rtl/memory_sequencer.sv
// memory_sequencer: queued instruction sequencer for the memory port; issue 2 cycles after accept, flush/abc NOPs inserted.
// instr_ready_out drops when the queue is full or after END; define MEMORY_SEQUENCER_TIMEOUT_EN to bound WAIT_ABC.

module seq_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_dat   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push && !o_full)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop  && !o_empty) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push && !o_full) r_mem[r_wr_ptr[AW-1:0]] <= i_dat;
  end
endmodule

module memory_sequencer #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int FIFO_DEPTH        = 4,
  parameter int TIMEOUT_CYCLES    = 8
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [INSTRUCTION_WIDTH-1:0] instr_in,
  input  logic                         instr_valid_in,
  output logic                         instr_ready_out,
  output logic [INSTRUCTION_WIDTH-1:0] mem_instr_out,
  output logic                         mem_instr_valid_out,
  input  logic                         buffer_valid_in,
  output logic                         buffer_ack_out,
  input  logic                         fma_ready_in,
  input  logic                         abc_valid_in,
  output logic                         done_out,
  output logic                         error_out,
  output logic [15:0]                  issued_count_out
);
  localparam int W = INSTRUCTION_WIDTH;

  localparam logic [3:0] OP_NOP    = 4'b0000;
  localparam logic [3:0] OP_END    = 4'b0001;
  localparam logic [3:0] OP_SMA    = 4'b0110;
  localparam logic [3:0] OP_LOADI  = 4'b0111;
  localparam logic [3:0] OP_LOADB  = 4'b1010;
  localparam logic [3:0] OP_WRITEB = 4'b1100;
  localparam logic [3:0] OP_SENDL  = 4'b1110;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_FLUSH, S_WAIT_ABC, S_DONE} state_t;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("memory_sequencer: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
  end

  state_t       r_state, w_state_nxt;
  logic [W-1:0] r_instr, w_instr_nxt;
  logic [W-1:0] r_mem_instr, w_mem_instr_nxt;
  logic         r_mem_vld, w_mem_vld_nxt;
  logic         r_ack, w_ack_nxt;
  logic         r_done, w_done_nxt;
  logic         r_error, w_error_nxt;
  logic [15:0]  r_count, w_count_nxt;
  logic         w_push, w_pop, w_full, w_empty;
  logic [W-1:0] w_head;
  logic [3:0]   w_head_op, w_cur_op;
  logic         w_issue_go;

`ifdef MEMORY_SEQUENCER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] r_to_cnt, w_to_cnt_nxt;
`endif

  seq_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (clk_in),
    .i_rst_n (rst_in),
    .i_push  (w_push),
    .i_dat   (instr_in),
    .i_pop   (w_pop),
    .o_dat   (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign instr_ready_out = !w_full && !r_done;
  assign w_push          = instr_valid_in && instr_ready_out;
  assign w_head_op       = w_head[W-1 -: 4];
  assign w_cur_op        = r_instr[W-1 -: 4];
  // LOADB waits for a buffered line, WRITEB for the FMA blocks; everything else issues at once.
  assign w_issue_go      = (w_cur_op == OP_LOADB)  ? buffer_valid_in :
                           (w_cur_op == OP_WRITEB) ? fma_ready_in    : 1'b1;

  always_comb begin
    w_state_nxt     = r_state;
    w_instr_nxt     = r_instr;
    w_mem_instr_nxt = '0;
    w_mem_vld_nxt   = 1'b0;
    w_ack_nxt       = 1'b0;
    w_done_nxt      = r_done;
    w_error_nxt     = r_error;
    w_count_nxt     = r_count;
    w_pop           = 1'b0;
`ifdef MEMORY_SEQUENCER_TIMEOUT_EN
    w_to_cnt_nxt    = '0;
`endif
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          case (w_head_op)
            OP_NOP: ;
            OP_END: begin
              w_state_nxt = S_DONE;
              w_done_nxt  = 1'b1;
            end
            OP_SMA, OP_LOADI, OP_SENDL, OP_LOADB, OP_WRITEB: begin
              w_instr_nxt = w_head;
              w_state_nxt = S_ISSUE;
            end
            default: w_error_nxt = 1'b1;
          endcase
        end
      end
      S_ISSUE: begin
        if (w_issue_go) begin
          w_mem_vld_nxt   = 1'b1;
          w_mem_instr_nxt = r_instr;
          w_count_nxt     = r_count + 16'd1;
          w_ack_nxt       = (w_cur_op == OP_LOADB);
          case (w_cur_op)
            OP_SENDL, OP_LOADB: w_state_nxt = S_FLUSH;
            OP_WRITEB:          w_state_nxt = S_WAIT_ABC;
            default:            w_state_nxt = S_IDLE;
          endcase
        end
      end
      S_FLUSH: begin
        w_mem_vld_nxt = 1'b1;
        w_state_nxt   = S_IDLE;
      end
      S_WAIT_ABC: begin
        if (abc_valid_in) begin
          w_state_nxt = S_IDLE;
        end else begin
`ifdef MEMORY_SEQUENCER_TIMEOUT_EN
          if (r_to_cnt == TO_LAST) begin
            w_error_nxt = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_mem_vld_nxt = 1'b1;
            w_to_cnt_nxt  = r_to_cnt + 1'b1;
          end
`else
          w_mem_vld_nxt = 1'b1;
`endif
        end
      end
      S_DONE: ;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state     <= S_IDLE;
      r_instr     <= '0;
      r_mem_instr <= '0;
      r_mem_vld   <= 1'b0;
      r_ack       <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_count     <= '0;
`ifdef MEMORY_SEQUENCER_TIMEOUT_EN
      r_to_cnt    <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_instr     <= w_instr_nxt;
      r_mem_instr <= w_mem_instr_nxt;
      r_mem_vld   <= w_mem_vld_nxt;
      r_ack       <= w_ack_nxt;
      r_done      <= w_done_nxt;
      r_error     <= w_error_nxt;
      r_count     <= w_count_nxt;
`ifdef MEMORY_SEQUENCER_TIMEOUT_EN
      r_to_cnt    <= w_to_cnt_nxt;
`endif
    end
  end

  assign mem_instr_out       = r_mem_instr;
  assign mem_instr_valid_out = r_mem_vld;
  assign buffer_ack_out      = r_ack;
  assign done_out            = r_done;
  assign error_out           = r_error;
  assign issued_count_out    = r_count;
endmodule

// File: doc/memory_sequencer.md
MEMORY_SEQUENCER -- requirements
Module: memory_sequencer

Interface
REQ-001 SHALL have parameter INSTRUCTION_WIDTH, default 32, instruction word width, opcode in bits [0:3] (MSB-first, as memory consumes it).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, power of two ≥2, upstream instruction queue depth.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 8, maximum WAIT_ABC cycles (used only under REQ-030).
REQ-004 SHALL have clk_in  input  1  single clock; all state on rising edge.
REQ-005 SHALL have rst_in  input  1  asynchronous active-low reset.
REQ-006 SHALL have instr_in  input  INSTRUCTION_WIDTH  upstream instruction.
REQ-007 SHALL have instr_valid_in  input  1, and instr_ready_out  output  1; transfer when both high on a clock edge.
REQ-008 SHALL have mem_instr_out  output  INSTRUCTION_WIDTH, and mem_instr_valid_out  output  1, driving memory instr_in / instr_valid_in.
REQ-009 SHALL have buffer_valid_in  input  1 (FMA write buffer holds a line), and buffer_ack_out  output  1 (one-cycle pulse: line taken).
REQ-010 SHALL have fma_ready_in  input  1 (FMA blocks can accept abc), and abc_valid_in  input  1 (memory abc_valid_out).
REQ-011 SHALL have done_out  output  1, error_out  output  1, issued_count_out  output  16.

Function
REQ-012 SHALL queue accepted instructions in a FIFO; instr_ready_out = FIFO not full AND done_out low (combinational).
REQ-013 SHALL run FSM states IDLE, ISSUE, FLUSH, WAIT_ABC, DONE; all outputs registered.
REQ-014 IDLE: FIFO empty -> stay; head present -> pop, decode opcode, go to ISSUE, or per REQ-019/020.
REQ-015 SMA (0110), LOADI (0111): issue for exactly one cycle (mem_instr_valid_out=1, mem_instr_out=instruction), then IDLE.
REQ-016 SENDL (1110): issue one cycle, then FLUSH: drive NOP (all zeros) valid for exactly one cycle, then IDLE.
REQ-017 LOADB (1010): hold in ISSUE with valid low until buffer_valid_in=1; in the issue cycle pulse buffer_ack_out; then FLUSH as REQ-016.
REQ-018 WRITEB (1100): hold until fma_ready_in=1; issue one cycle; then WAIT_ABC: drive NOP valid every cycle until abc_valid_in sampled 1, then IDLE (valid low next cycle).
REQ-019 Upstream NOP (0000): pop and discard, no issue, no extra cycle.
REQ-020 END (0001): pop, go to DONE, done_out=1 sticky; instructions still queued are left unissued; exit only by reset.
REQ-021 Any other opcode: pop and discard, error_out=1 sticky until reset.
REQ-022 mem_instr_out SHALL be all zeros whenever mem_instr_valid_out=0.
REQ-023 issued_count_out SHALL increment once per non-NOP instruction issued to memory (flush NOPs excluded); wraps 0xFFFF->0.
REQ-024 Latency: instruction accepted at edge N into empty FIFO in IDLE -> mem_instr_valid_out high during cycle after edge N+2 (one cycle pop/decode, one registered issue); back-to-back SMA/LOADI issue every 2 cycles.
REQ-025 Simultaneous push and pop on full FIFO SHALL be disallowed by ready; simultaneous push/pop otherwise keeps count unchanged.

Reset
REQ-026 rst_in low SHALL asynchronously force: FSM IDLE, FIFO empty, mem_instr_valid_out=0, mem_instr_out=0, buffer_ack_out=0, done_out=0, error_out=0, issued_count_out=0, timeout counter 0.
REQ-027 Reset mid-WAIT_ABC or mid-FLUSH SHALL abort; no further NOP driven after reset.
REQ-028 Release is synchronous to clk_in; first pop no earlier than first edge after release.

Configuration
REQ-029 Macro MEMORY_SEQUENCER_TIMEOUT_EN SHALL select abc timeout.
REQ-030 Defined: WAIT_ABC counting TIMEOUT_CYCLES cycles without abc_valid_in -> set error_out, go IDLE. Undefined: WAIT_ABC waits indefinitely; TIMEOUT_CYCLES unused.

Verification
REQ-031 SMA 0x6000_2A00 then LOADI 0x7100_1234 -> two issues, identical words, count=2, no NOPs.
REQ-032 SENDL 0xE000_0000 -> issue then exactly one all-zero valid NOP cycle, count=1.
REQ-033 LOADB with buffer_valid_in low 5 cycles then high -> no issue for 5 cycles; issue and buffer_ack_out pulse same cycle; then one NOP.
REQ-034 WRITEB, abc_valid_in high 3 cycles after issue -> NOP valid 3 cycles, then valid low; timeout build with abc never high -> error_out=1 after 8 cycles.
REQ-035 Push 5 instructions with no pops possible (LOADB stalled) -> instr_ready_out low when 4 queued; END reaches head -> done_out=1, ready stays low.
REQ-036 Opcode 0010 -> discarded, error_out=1, count unchanged; reset low mid-WAIT_ABC -> all outputs zero immediately.
